// File: rtl/axi_arb_pkg.sv
// Shared types and helpers for the AXI AW round-robin arbiter.
//  - state_t   : arbiter FSM states
//  - aw_t      : unpacked view of one AW beat, fields at their maximum AXI widths
//  - aw_width  : packed AW width for given addr/user/id widths
//  - aw_pack / aw_unpack : convert between aw_t and the packed bus layout
//    {cache,prot,lock,burst,size,len,qos,region,addr,user,id}, id in the LSBs.
//    The packed result is right-aligned in AW_MAX_W bits; callers truncate to aw_width().
package axi_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // cache(4)+prot(3)+lock(1)+burst(2)+size(3)+len(8)+qos(4)+region(4)
    localparam int AW_HDR_W = 29;
    localparam int AW_MAX_W = AW_HDR_W + 64 + 32 + 16;

    typedef struct packed {
        logic [3:0]  cache;
        logic [2:0]  prot;
        logic        lock;
        logic [1:0]  burst;
        logic [2:0]  size;
        logic [7:0]  len;
        logic [3:0]  qos;
        logic [3:0]  region;
        logic [63:0] addr;
        logic [31:0] user;
        logic [15:0] id;
    } aw_t;

    function automatic int aw_width(input int addr_w, input int user_w, input int id_w);
        return AW_HDR_W + addr_w + user_w + id_w;
    endfunction

    function automatic logic [AW_MAX_W-1:0] aw_mask(input int w);
        return (AW_MAX_W'(1) << w) - AW_MAX_W'(1);
    endfunction

    function automatic logic [AW_MAX_W-1:0] aw_pack(input aw_t f, input int addr_w,
                                                    input int user_w, input int id_w);
        logic [AW_MAX_W-1:0] r;
        r = AW_MAX_W'({f.cache, f.prot, f.lock, f.burst, f.size, f.len, f.qos, f.region});
        r = (r << addr_w) | (AW_MAX_W'(f.addr) & aw_mask(addr_w));
        r = (r << user_w) | (AW_MAX_W'(f.user) & aw_mask(user_w));
        r = (r << id_w)   | (AW_MAX_W'(f.id)   & aw_mask(id_w));
        return r;
    endfunction

    function automatic aw_t aw_unpack(input logic [AW_MAX_W-1:0] v, input int addr_w,
                                      input int user_w, input int id_w);
        aw_t                 f;
        logic [AW_MAX_W-1:0] r;
        logic [AW_HDR_W-1:0] hdr;
        r      = v;
        f.id   = 16'(r & aw_mask(id_w));
        r      = r >> id_w;
        f.user = 32'(r & aw_mask(user_w));
        r      = r >> user_w;
        f.addr = 64'(r & aw_mask(addr_w));
        r      = r >> addr_w;
        hdr    = AW_HDR_W'(r);
        {f.cache, f.prot, f.lock, f.burst, f.size, f.len, f.qos, f.region} = hdr;
        return f;
    endfunction

endpackage

// File: rtl/axi_route_fifo.sv
// Route FIFO: remembers which requester owns each accepted AW so the W mux
// can steer data bursts in AW order.
// Ports:
//  clk_i, rst_i      clock, synchronous active-high reset
//  push_i, data_i    write an entry (accepted when not full, or when popping too)
//  pop_i             drop the head entry (ignored while empty)
//  data_o            head entry, 0 while empty
//  empty_o, full_o   occupancy status
module axi_route_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             empty_o,
    output logic             full_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    // A push into a full FIFO is fine when the head leaves in the same cycle.
    assign do_push = push_i && (!full_o || pop_i);
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/axi_aw_rr_arbiter.sv
// Round-robin arbiter sharing one AXI AW master port between N_SLAVES requesters.
// Each accepted AW records its requester index in a route FIFO for the W mux.
// Ports:
//  clk_i, rst_i     clock, synchronous active-high reset
//  slave_valid_i    per-requester AW valid
//  slave_aw_i       per-requester packed AW, slot k at [k*AW_W +: AW_W]
//  slave_ready_o    per-requester AW ready (one-hot or zero)
//  master_valid_o   AW valid to the buffer
//  master_aw_o      packed AW of the granted requester
//  master_ready_i   AW ready from the buffer
//  route_valid_o    route FIFO non-empty
//  route_sel_o      requester index at the route FIFO head
//  route_pop_i      W mux finished a burst; pops the head
//  route_full_o     route FIFO full
module axi_aw_rr_arbiter
    import axi_arb_pkg::*;
#(
    parameter int N_SLAVES    = 4,
    parameter int ID_WIDTH    = 4,
    parameter int ADDR_WIDTH  = 32,
    parameter int USER_WIDTH  = 6,
    parameter int ROUTE_DEPTH = 4,
    localparam int AW_W  = aw_width(ADDR_WIDTH, USER_WIDTH, ID_WIDTH),
    localparam int SEL_W = $clog2(N_SLAVES)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [N_SLAVES-1:0]      slave_valid_i,
    input  logic [N_SLAVES*AW_W-1:0] slave_aw_i,
    output logic [N_SLAVES-1:0]      slave_ready_o,
    output logic                     master_valid_o,
    output logic [AW_W-1:0]          master_aw_o,
    input  logic                     master_ready_i,
    output logic                     route_valid_o,
    output logic [SEL_W-1:0]         route_sel_o,
    input  logic                     route_pop_i,
    output logic                     route_full_o
);
    state_t           state_q, state_d;
    logic [SEL_W-1:0] grant_q, grant_d;
    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [SEL_W-1:0] pick;
    logic             found;
    logic             push;
    logic             route_empty;

    // (base + off) mod N_SLAVES without a divider; off < N_SLAVES.
    function automatic logic [SEL_W-1:0] rr_idx(input logic [SEL_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N_SLAVES) s = s - N_SLAVES;
        return SEL_W'(s);
    endfunction

    // First valid requester at or after rr_ptr, wrapping.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (!found && slave_valid_i[rr_idx(rr_ptr_q, i)]) begin
                found = 1'b1;
                pick  = rr_idx(rr_ptr_q, i);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        push     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!route_full_o && found) begin
                    grant_d = pick;
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (master_ready_i) begin
                    push     = 1'b1;
                    rr_ptr_d = rr_idx(grant_q, 1);
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Outputs depend only on registered grant state plus master_ready_i, so
    // there is no path from slave_valid_i to slave_ready_o.
    always_comb begin
        master_valid_o = 1'b0;
        master_aw_o    = '0;
        slave_ready_o  = '0;
        if (state_q == LOCKED) begin
            master_valid_o         = 1'b1;
            master_aw_o            = slave_aw_i[int'(grant_q)*AW_W +: AW_W];
            slave_ready_o[grant_q] = master_ready_i;
        end
    end

    axi_route_fifo #(
        .WIDTH (SEL_W),
        .DEPTH (ROUTE_DEPTH)
    ) u_route_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .pop_i   (route_pop_i),
        .data_i  (grant_q),
        .data_o  (route_sel_o),
        .empty_o (route_empty),
        .full_o  (route_full_o)
    );

    assign route_valid_o = !route_empty;

endmodule

// File: tb/tb_axi_aw_rr_arbiter.sv
// Directed-vector bench for axi_aw_rr_arbiter plus a short direct sequence on
// the route FIFO for the push+pop-while-full case.
module tb_axi_aw_rr_arbiter;
    import axi_arb_pkg::*;

    localparam int N     = 4;
    localparam int IDW   = 4;
    localparam int AWD   = 32;
    localparam int UW    = 6;
    localparam int RD    = 4;
    localparam int AW_W  = aw_width(AWD, UW, IDW);
    localparam int SEL_W = 2;
    localparam logic T = 1'b1;
    localparam logic F = 1'b0;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [N-1:0]        slave_valid = '0;
    logic [N*AW_W-1:0]   slave_aw = '0;
    logic [N-1:0]        slave_ready;
    logic                master_valid;
    logic [AW_W-1:0]     master_aw;
    logic                master_ready = 1'b0;
    logic                route_valid;
    logic [SEL_W-1:0]    route_sel;
    logic                route_pop = 1'b0;
    logic                route_full;

    logic                f_push = 1'b0;
    logic                f_pop = 1'b0;
    logic [SEL_W-1:0]    f_data = '0;
    logic [SEL_W-1:0]    f_dout;
    logic                f_empty;
    logic                f_full;

    always #5 clk = ~clk;

    axi_aw_rr_arbiter #(
        .N_SLAVES(N), .ID_WIDTH(IDW), .ADDR_WIDTH(AWD), .USER_WIDTH(UW), .ROUTE_DEPTH(RD)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .slave_valid_i(slave_valid), .slave_aw_i(slave_aw), .slave_ready_o(slave_ready),
        .master_valid_o(master_valid), .master_aw_o(master_aw), .master_ready_i(master_ready),
        .route_valid_o(route_valid), .route_sel_o(route_sel), .route_pop_i(route_pop),
        .route_full_o(route_full)
    );

    axi_route_fifo #(.WIDTH(SEL_W), .DEPTH(RD)) u_fifo (
        .clk_i(clk), .rst_i(rst), .push_i(f_push), .pop_i(f_pop), .data_i(f_data),
        .data_o(f_dout), .empty_o(f_empty), .full_o(f_full)
    );

    typedef struct {
        logic             rst;
        logic [N-1:0]     valid;
        logic             ready;
        logic             pop;
        logic             mv;
        logic [SEL_W-1:0] g;
        logic [N-1:0]     srdy;
        logic             rv;
        logic [SEL_W-1:0] sel;
        logic             full;
    } vec_t;

    vec_t            vecs[$];
    logic [AW_W-1:0] slice [N];
    int              errors = 0;
    int              checks = 0;

    function automatic void add(input logic r, input logic [N-1:0] va, input logic rd,
                                input logic pp, input logic mv, input logic [SEL_W-1:0] g,
                                input logic [N-1:0] sr, input logic rv,
                                input logic [SEL_W-1:0] sel, input logic fu);
        vec_t v;
        v.rst = r; v.valid = va; v.ready = rd; v.pop = pp;
        v.mv = mv; v.g = g; v.srdy = sr; v.rv = rv; v.sel = sel; v.full = fu;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [AW_W-1:0] act, input logic [AW_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fdrive(input logic p, input logic q, input logic [SEL_W-1:0] d);
        @(negedge clk);
        f_push = p; f_pop = q; f_data = d;
        @(posedge clk);
        #1;
        f_push = 1'b0; f_pop = 1'b0;
    endtask

    initial begin
        logic [AW_W-1:0] exp_aw;

        for (int k = 0; k < N; k++) begin
            aw_t f;
            f.cache  = 4'(k + 1);
            f.prot   = 3'(k);
            f.lock   = 1'(k);
            f.burst  = 2'(k);
            f.size   = 3'(k + 2);
            f.len    = 8'(16 * k + 3);
            f.qos    = 4'(15 - k);
            f.region = 4'(k + 8);
            f.addr   = 64'(32'h1000_0000 * (k + 1) + 32'h40 * k);
            f.user   = 32'(6'h2a ^ 6'(k));
            f.id     = 16'(k + 5);
            slice[k] = AW_W'(aw_pack(f, AWD, UW, IDW));
            slave_aw[k*AW_W +: AW_W] = slice[k];
        end

        //  rst valid    rdy pop  mv g      srdy     rv sel   full
        add(F, 4'b0000, F, F,   F, 2'd0, 4'b0000, F, 2'd0, F);  // reset state
        // single requester 2, next search starts at 3
        add(F, 4'b0100, T, F,   F, 2'd0, 4'b0000, F, 2'd0, F);
        add(F, 4'b0100, T, F,   T, 2'd2, 4'b0100, F, 2'd0, F);
        add(F, 4'b0000, T, F,   F, 2'd0, 4'b0000, T, 2'd2, F);
        add(F, 4'b1100, T, F,   F, 2'd0, 4'b0000, T, 2'd2, F);
        add(F, 4'b1100, T, F,   T, 2'd3, 4'b1000, T, 2'd2, F);
        add(F, 4'b0000, F, T,   F, 2'd0, 4'b0000, T, 2'd2, F);
        add(F, 4'b0000, F, T,   F, 2'd0, 4'b0000, T, 2'd3, F);
        add(F, 4'b0000, F, F,   F, 2'd0, 4'b0000, F, 2'd0, F);
        // all valid, ready high: grants 0,1,2,3,0 every other cycle
        add(F, 4'b1111, T, T,   F, 2'd0, 4'b0000, F, 2'd0, F);
        add(F, 4'b1111, T, T,   T, 2'd0, 4'b0001, F, 2'd0, F);
        add(F, 4'b1111, T, T,   F, 2'd0, 4'b0000, T, 2'd0, F);
        add(F, 4'b1111, T, T,   T, 2'd1, 4'b0010, F, 2'd0, F);
        add(F, 4'b1111, T, T,   F, 2'd0, 4'b0000, T, 2'd1, F);
        add(F, 4'b1111, T, T,   T, 2'd2, 4'b0100, F, 2'd0, F);
        add(F, 4'b1111, T, T,   F, 2'd0, 4'b0000, T, 2'd2, F);
        add(F, 4'b1111, T, T,   T, 2'd3, 4'b1000, F, 2'd0, F);
        add(F, 4'b1111, T, T,   F, 2'd0, 4'b0000, T, 2'd3, F);
        add(F, 4'b1111, T, T,   T, 2'd0, 4'b0001, F, 2'd0, F);
        add(F, 4'b0000, T, T,   F, 2'd0, 4'b0000, T, 2'd0, F);
        add(F, 4'b0000, F, F,   F, 2'd0, 4'b0000, F, 2'd0, F);
        // slave 1 held for five cycles of backpressure
        add(F, 4'b0010, F, F,   F, 2'd0, 4'b0000, F, 2'd0, F);
        for (int i = 0; i < 5; i++)
            add(F, 4'b0010, F, F, T, 2'd1, 4'b0000, F, 2'd0, F);
        add(F, 4'b0010, T, F,   T, 2'd1, 4'b0010, F, 2'd0, F);
        add(F, 4'b0000, F, F,   F, 2'd0, 4'b0000, T, 2'd1, F);
        add(F, 4'b0000, F, T,   F, 2'd0, 4'b0000, T, 2'd1, F);
        add(F, 4'b0000, F, F,   F, 2'd0, 4'b0000, F, 2'd0, F);
        // fill the route FIFO without pops: 4 grants then stall
        add(F, 4'b1111, T, F,   F, 2'd0, 4'b0000, F, 2'd0, F);
        add(F, 4'b1111, T, F,   T, 2'd2, 4'b0100, F, 2'd0, F);
        add(F, 4'b1111, T, F,   F, 2'd0, 4'b0000, T, 2'd2, F);
        add(F, 4'b1111, T, F,   T, 2'd3, 4'b1000, T, 2'd2, F);
        add(F, 4'b1111, T, F,   F, 2'd0, 4'b0000, T, 2'd2, F);
        add(F, 4'b1111, T, F,   T, 2'd0, 4'b0001, T, 2'd2, F);
        add(F, 4'b1111, T, F,   F, 2'd0, 4'b0000, T, 2'd2, F);
        add(F, 4'b1111, T, F,   T, 2'd1, 4'b0010, T, 2'd2, F);
        add(F, 4'b1111, T, F,   F, 2'd0, 4'b0000, T, 2'd2, T);
        add(F, 4'b1111, T, F,   F, 2'd0, 4'b0000, T, 2'd2, T);
        add(F, 4'b1111, T, T,   F, 2'd0, 4'b0000, T, 2'd2, T);
        add(F, 4'b1111, T, F,   F, 2'd0, 4'b0000, T, 2'd3, F);
        add(F, 4'b1111, T, F,   T, 2'd2, 4'b0100, T, 2'd3, F);
        add(F, 4'b1111, T, F,   F, 2'd0, 4'b0000, T, 2'd3, T);
        // lock on slave 3 with ready low, then reset mid-lock
        add(F, 4'b1111, F, T,   F, 2'd0, 4'b0000, T, 2'd3, T);
        add(F, 4'b1111, F, F,   F, 2'd0, 4'b0000, T, 2'd0, F);
        add(F, 4'b1111, F, F,   T, 2'd3, 4'b0000, T, 2'd0, F);
        add(T, 4'b1111, F, F,   T, 2'd3, 4'b0000, T, 2'd0, F);
        add(F, 4'b1111, F, F,   F, 2'd0, 4'b0000, F, 2'd0, F);
        add(F, 4'b1111, F, F,   T, 2'd0, 4'b0000, F, 2'd0, F);

        repeat (3) @(posedge clk);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst          = vecs[i].rst;
            slave_valid  = vecs[i].valid;
            master_ready = vecs[i].ready;
            route_pop    = vecs[i].pop;
            #1;
            exp_aw = vecs[i].mv ? slice[vecs[i].g] : '0;
            chk($sformatf("v%0d master_valid", i), AW_W'(master_valid), AW_W'(vecs[i].mv));
            chk($sformatf("v%0d master_aw", i), master_aw, exp_aw);
            chk($sformatf("v%0d slave_ready", i), AW_W'(slave_ready), AW_W'(vecs[i].srdy));
            chk($sformatf("v%0d route_valid", i), AW_W'(route_valid), AW_W'(vecs[i].rv));
            chk($sformatf("v%0d route_sel", i), AW_W'(route_sel), AW_W'(vecs[i].sel));
            chk($sformatf("v%0d route_full", i), AW_W'(route_full), AW_W'(vecs[i].full));
        end

        @(negedge clk);
        rst = 1'b0; slave_valid = '0; master_ready = 1'b0; route_pop = 1'b0;

        // Route FIFO directly: fill, then push+pop while full.
        fdrive(T, F, 2'd1);
        fdrive(T, F, 2'd2);
        fdrive(T, F, 2'd3);
        chk("fifo full after 3", AW_W'(f_full), AW_W'(F));
        fdrive(T, F, 2'd0);
        chk("fifo full after 4", AW_W'(f_full), AW_W'(T));
        chk("fifo head after 4", AW_W'(f_dout), AW_W'(2'd1));
        fdrive(T, T, 2'd2);
        chk("fifo full after push+pop", AW_W'(f_full), AW_W'(T));
        chk("fifo head after push+pop", AW_W'(f_dout), AW_W'(2'd2));
        fdrive(F, T, 2'd0);
        chk("fifo head pop1", AW_W'(f_dout), AW_W'(2'd3));
        fdrive(F, T, 2'd0);
        chk("fifo head pop2", AW_W'(f_dout), AW_W'(2'd0));
        fdrive(F, T, 2'd0);
        chk("fifo head pop3", AW_W'(f_dout), AW_W'(2'd2));
        chk("fifo not empty pop3", AW_W'(f_empty), AW_W'(F));
        fdrive(F, T, 2'd0);
        chk("fifo empty pop4", AW_W'(f_empty), AW_W'(T));
        chk("fifo empty data", AW_W'(f_dout), AW_W'(2'd0));
        fdrive(F, T, 2'd0);
        chk("fifo pop while empty", AW_W'(f_empty), AW_W'(T));
        fdrive(T, F, 2'd3);
        chk("fifo refill empty", AW_W'(f_empty), AW_W'(F));
        chk("fifo refill head", AW_W'(f_dout), AW_W'(2'd3));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
